// File: rtl/brg_sram_1024x46_arbiter.sv
// brg_sram_1024x46_arbiter
//   Two-requester arbiter/sequencer in front of the 1024x46 single-port SRAM
//   wrapper. Port 0 is the core load/store path, port 1 the remote network.
//   Requests use valid/ready. Grants are round-robin, one access per cycle.
//   Read data returns per port through a one-entry response slot that is
//   released by yumi, so a stalled requester never blocks the other port.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   v_i, w_i              per-port request valid / write (1) or read (0)
//   addr_i, data_i        per-port address and write data, port k in slice k
//   ready_o               one-hot grant (request accepted this cycle)
//   resp_v_o, resp_data_o per-port read response valid / data
//   resp_yumi_i           per-port response consumed
//   sram_*_o, sram_data_i SRAM macro interface (1-cycle read latency)
module brg_sram_1024x46_arbiter #(
  parameter int width_p       = 46,
  parameter int els_p         = 1024,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 v_i,
  input  logic [1:0]                 w_i,
  input  logic [2*addr_width_lp-1:0] addr_i,
  input  logic [2*width_p-1:0]       data_i,
  output logic [1:0]                 ready_o,
  output logic [1:0]                 resp_v_o,
  output logic [2*width_p-1:0]       resp_data_o,
  input  logic [1:0]                 resp_yumi_i,
  output logic                       sram_v_o,
  output logic                       sram_w_o,
  output logic [addr_width_lp-1:0]   sram_addr_o,
  output logic [width_p-1:0]         sram_data_o,
  input  logic [width_p-1:0]         sram_data_i
);

  logic               last_r;     // port granted most recently
  logic [1:0]         pend_r;     // read issued last cycle: data is on sram_data_i now
  logic [1:0]         hold_v_r;   // response parked in hold_r awaiting yumi
  logic [width_p-1:0] hold_r [2];

  logic [1:0] elig;
  logic [1:0] grant;
  logic       sel;

  // Response slot: bypass straight from the SRAM in the cycle after the read,
  // then from the holding register once the requester has stalled.
  always_comb begin
    resp_v_o    = (pend_r | hold_v_r) & ~{2{reset_i}};
    resp_data_o = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (!reset_i)
        resp_data_o[k*width_p +: width_p] = pend_r[k] ? sram_data_i : hold_r[k];
    end
  end

  // A read needs a free slot, or one being freed this cycle by yumi.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < 2; k++)
      elig[k] = ~reset_i & v_i[k] & (w_i[k] | ~resp_v_o[k] | resp_yumi_i[k]);
  end

  always_comb begin
    if (&elig)
      grant = last_r ? 2'b01 : 2'b10;
    else
      grant = elig;
  end

  assign sel     = grant[1];
  assign ready_o = grant;

  always_comb begin
    sram_v_o    = |grant;
    sram_w_o    = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    if (|grant) begin
      sram_w_o    = w_i[sel];
      sram_addr_o = sel ? addr_i[2*addr_width_lp-1:addr_width_lp]
                        : addr_i[addr_width_lp-1:0];
      sram_data_o = sel ? data_i[2*width_p-1:width_p]
                        : data_i[width_p-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_r    <= 1'b1;
      pend_r    <= '0;
      hold_v_r  <= '0;
      hold_r[0] <= '0;
      hold_r[1] <= '0;
    end else begin
      if (|grant)
        last_r <= grant[1];
      pend_r   <= grant & ~w_i;
      // A new read is only granted when the slot empties, so the parked
      // state never overlaps a fresh bypass response on the same port.
      hold_v_r <= resp_v_o & ~resp_yumi_i;
      for (int unsigned k = 0; k < 2; k++) begin
        if (pend_r[k] && !resp_yumi_i[k])
          hold_r[k] <= sram_data_i;
      end
    end
  end

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    ((resp_yumi_i & ~resp_v_o) == 2'b00));

endmodule
